// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers: per-channel synchronizer, stability FSM,
// edge pulses and optional auto-repeat while a channel is held high.
module debounce_bank #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] pulse,
  output logic            busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CHK_LO = 2'd3
  } state_t;

  logic [N_CH-1:0] chk_vec;

  assign busy = |chk_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      state_t                 state_q, state_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      logic                   pulse_q, pulse_d;
      logic                   legal;
      logic                   edge_pulse;
      logic                   rep_pulse;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], sw[gi]};
        end
      end

      assign s = sync_q[SYNC_STAGES-1];

      // Each check starts from count 1 (the sample that left the stable state)
      // and any opposite sample throws the partial count away.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        legal   = 1'b1;
        case (state_q)
          ST_LOW: begin
            if (s) begin
              state_d = ST_CHK_HI;
              cnt_d   = CW'(1);
            end
          end
          ST_CHK_HI: begin
            if (!s) begin
              state_d = ST_LOW;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          ST_HIGH: begin
            if (!s) begin
              state_d = ST_CHK_LO;
              cnt_d   = CW'(1);
            end
          end
          ST_CHK_LO: begin
            if (s) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_LOW;
              cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            legal   = 1'b0;
          end
        endcase
      end

      always_comb begin
        level_d = (state_d == ST_HIGH) || (state_d == ST_CHK_LO);
        rise_d  = legal && level_d && !level_q;
        fall_d  = legal && !level_d && level_q;
        case (EDGE_MODE)
          1:       edge_pulse = fall_d;
          2:       edge_pulse = rise_d || fall_d;
          default: edge_pulse = rise_d;
        endcase
        pulse_d = edge_pulse || rep_pulse;
      end

      if (REPEAT_CYCLES > 0) begin : g_rep
        localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;
        localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
        localparam logic [RW-1:0] REP_MAX  = '1;
        logic [RW-1:0] rep_q, rep_d;
        logic          rep_fire;

        // Gating on the next level keeps a repeat from landing on the fall cycle.
        always_comb begin
          rep_d    = rep_q;
          rep_fire = 1'b0;
          if (rise_d || !level_d) begin
            rep_d = '0;
          end else if (rep_q == REP_LAST) begin
            rep_d    = '0;
            rep_fire = 1'b1;
          end else if (rep_q != REP_MAX) begin
            rep_d = rep_q + RW'(1);
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            rep_q <= '0;
          end else begin
            rep_q <= rep_d;
          end
        end

        assign rep_pulse = rep_fire;
      end else begin : g_norep
        assign rep_pulse = 1'b0;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= ST_LOW;
          cnt_q   <= '0;
          level_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
          pulse_q <= pulse_d;
        end
      end

      assign chk_vec[gi] = (state_q == ST_CHK_HI) || (state_q == ST_CHK_LO);
      assign level[gi]   = level_q;
      assign rise[gi]    = rise_q;
      assign fall[gi]    = fall_q;
      assign pulse[gi]   = pulse_q;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: default, both-edge and auto-repeat instances
// share clock, reset and switch stimulus; each is checked for its own behaviour.
module tb_debounce_bank;

  logic       clk;
  logic       rst;
  logic [3:0] sw;

  logic [3:0] lv0, ri0, fa0, pu0;
  logic       bz0;
  logic [3:0] lv2, ri2, fa2, pu2;
  logic       bz2;
  logic [3:0] lvr, rir, far, pur;
  logic       bzr;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  debounce_bank dut0 (
    .clk(clk), .rst(rst), .sw(sw),
    .level(lv0), .rise(ri0), .fall(fa0), .pulse(pu0), .busy(bz0)
  );

  debounce_bank #(.EDGE_MODE(2)) dut_m2 (
    .clk(clk), .rst(rst), .sw(sw),
    .level(lv2), .rise(ri2), .fall(fa2), .pulse(pu2), .busy(bz2)
  );

  debounce_bank #(.REPEAT_CYCLES(20)) dut_rp (
    .clk(clk), .rst(rst), .sw(sw),
    .level(lvr), .rise(rir), .fall(far), .pulse(pur), .busy(bzr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    logic [3:0] acc;
    logic       saw_busy;
    int         on_grid, stray;
    logic       fall120, pulse120;

    rst = 1'b1;
    sw  = 4'b0000;
    step(3);
    chk("reset_outputs", {15'd0, lv0, ri0, fa0, pu0, bz0}, 32'd0);
    chk("reset_outputs_rep", {15'd0, lvr, rir, far, pur, bzr}, 32'd0);
    rst = 1'b0;
    step(2);

    // Single channel rise: 10 edges after the first sampling edge
    sw = 4'b0001;
    step(2);
    chk("busy_before_check", bz0, 0);
    step(1);
    chk("busy_check_start", bz0, 1);
    step(6);
    chk("busy_check_end", bz0, 1);
    chk("level_edge9", lv0, 4'b0000);
    step(1);
    chk("level_edge10", lv0, 4'b0001);
    chk("rise_edge10", ri0, 4'b0001);
    chk("pulse_edge10", pu0, 4'b0001);
    chk("busy_after_accept", bz0, 0);
    step(1);
    chk("rise_one_cycle", ri0, 4'b0000);
    chk("pulse_one_cycle", pu0, 4'b0000);
    chk("level_held", lv0, 4'b0001);

    sw = 4'b0000;
    step(9);
    chk("fall_level_edge9", lv0, 4'b0001);
    step(1);
    chk("fall_level_edge10", lv0, 4'b0000);
    chk("fall_edge10", fa0, 4'b0001);
    chk("mode0_no_fall_pulse", pu0, 4'b0000);
    chk("mode2_fall_pulse", pu2, 4'b0001);
    step(3);

    // Bounce: 5 high / 5 low, four times, never accepted
    acc      = 4'b0000;
    saw_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sw = 4'b0010;
      for (int c = 0; c < 5; c++) begin
        step(1);
        acc      = acc | lv0 | ri0 | pu0;
        saw_busy = saw_busy | bz0;
      end
      sw = 4'b0000;
      for (int c = 0; c < 5; c++) begin
        step(1);
        acc      = acc | lv0 | ri0 | pu0;
        saw_busy = saw_busy | bz0;
      end
    end
    step(5);
    acc = acc | lv0 | ri0 | pu0;
    chk("bounce_no_accept", acc, 4'b0000);
    chk("bounce_busy_seen", saw_busy, 1);

    // One-cycle dropout restarts the count from scratch
    sw = 4'b0010;
    step(5);
    sw = 4'b0000;
    step(1);
    sw = 4'b0010;
    step(9);
    chk("restart_level_edge9", lv0, 4'b0000);
    step(1);
    chk("restart_rise_edge10", ri0, 4'b0010);
    sw = 4'b0000;
    step(10);
    chk("restart_fall", fa0, 4'b0010);
    step(3);

    // All channels together
    sw = 4'b1111;
    step(9);
    chk("all_rise_edge9", ri0, 4'b0000);
    step(1);
    chk("all_rise", ri0, 4'b1111);
    chk("all_rise_m2", ri2, 4'b1111);
    chk("all_pulse_m2_rise", pu2, 4'b1111);
    step(1);
    chk("all_rise_single", ri0, 4'b0000);
    sw = 4'b0000;
    step(10);
    chk("all_fall", fa0, 4'b1111);
    chk("all_fall_mode0_pulse", pu0, 4'b0000);
    chk("all_fall_m2", fa2, 4'b1111);
    chk("all_pulse_m2_fall", pu2, 4'b1111);
    step(1);
    chk("all_pulse_m2_single", pu2, 4'b0000);
    step(3);

    // Auto-repeat every 20 cycles; fall lands on what would be a repeat slot
    sw = 4'b0100;
    step(10);
    chk("rep_rise_pulse", pur, 4'b0100);
    on_grid  = 0;
    stray    = 0;
    fall120  = 1'b0;
    pulse120 = 1'b1;
    for (int j = 1; j <= 160; j++) begin
      step(1);
      if (pur[2]) begin
        if ((j % 20 == 0) && (j <= 100)) on_grid++;
        else stray++;
      end
      if (j == 120) begin
        fall120  = far[2];
        pulse120 = pur[2];
      end
      if (j == 110) sw = 4'b0000;
    end
    chk("rep_count", on_grid, 5);
    chk("rep_stray", stray, 0);
    chk("rep_fall_at_120", fall120, 1);
    chk("rep_suppressed_at_fall", pulse120, 0);
    chk("rep_level_end", lvr, 4'b0000);

    // Reset in the middle of a check, switches held through release
    sw = 4'b0001;
    step(10);
    chk("pre_reset_level", lv0, 4'b0001);
    sw = 4'b1001;
    step(8);
    chk("pre_reset_busy", bz0, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {15'd0, lv0, ri0, fa0, pu0, bz0}, 32'd0);
    chk("async_reset_rep", {15'd0, lvr, rir, far, pur, bzr}, 32'd0);
    step(2);
    rst = 1'b0;
    acc = 4'b0000;
    for (int c = 0; c < 9; c++) begin
      step(1);
      acc = acc | lv0 | ri0 | pu0;
    end
    chk("post_reset_quiet", acc, 4'b0000);
    step(1);
    chk("post_reset_rise", ri0, 4'b1001);
    chk("post_reset_level", lv0, 4'b1001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
